hazard_ctrl: RTL and testbench

//  Pipeline-control unit for the pipelined MIPS core. It drives the stall, bubble, flush and

---
 rtl/hazard_ctrl_if.sv | 43 ++++
 rtl/hazard_ctrl.sv | 156 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Pipeline-control bundle between the MIPS pipe stages (master) and hazard_ctrl (slave).
// Carries the ID/EX hazard sources in and the stall/flush/redirect controls plus perf counters out.
interface hazard_ctrl_if #(
    parameter int REG_W = 5,
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] RsAddr_ID;
    logic             UseRs_ID;
    logic [REG_W-1:0] RtAddr_ID;
    logic             UseRt_ID;
    logic [REG_W-1:0] DstAddr_EX;
    logic             RegWrite_EX;
    logic             MemToReg_EX;
    logic             Stall_EX;
    logic             BranchTaken_EX;
    logic [PC_W-1:0]  RedirectPc_EX;

    logic             AnyStall;
    logic             Bubble_EX;
    logic             Flush_IF;
    logic             Flush_ID;
    logic             Redirect_IF;
    logic [PC_W-1:0]  RedirectPc_IF;
    logic [CNT_W-1:0] StallCnt;
    logic [CNT_W-1:0] FlushCnt;
    logic [CNT_W-1:0] CycleCnt;
    logic             Done;

    modport master (
        output RsAddr_ID, UseRs_ID, RtAddr_ID, UseRt_ID, DstAddr_EX,
               RegWrite_EX, MemToReg_EX, Stall_EX, BranchTaken_EX, RedirectPc_EX,
        input  AnyStall, Bubble_EX, Flush_IF, Flush_ID, Redirect_IF, RedirectPc_IF,
               StallCnt, FlushCnt, CycleCnt, Done
    );

    modport slave (
        input  RsAddr_ID, UseRs_ID, RtAddr_ID, UseRt_ID, DstAddr_EX,
               RegWrite_EX, MemToReg_EX, Stall_EX, BranchTaken_EX, RedirectPc_EX,
        output AnyStall, Bubble_EX, Flush_IF, Flush_ID, Redirect_IF, RedirectPc_IF,
               StallCnt, FlushCnt, CycleCnt, Done
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, EX busy hold, taken-branch flush/redirect,
// saturating performance counters and a sticky cycle-limit flag.
module hazard_ctrl #(
    parameter int REG_W       = 5,
    parameter int PC_W        = 32,
    parameter int LOAD_LAT    = 1,
    parameter int FLUSH_DEPTH = 1,
    parameter int CNT_W       = 16,
    parameter int MAX_CYCLES  = 17
) (
    input  logic          clk,
    input  logic          reset,
    hazard_ctrl_if.slave  ctrl_io
);

    localparam int LDC_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT + 1) : 1;
    localparam int FLC_W = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        RUN,
        LDUSE,
        BUSY,
        FLUSH
    } state_e;

    state_e           state_q, state_d;
    logic [LDC_W-1:0] ldRem_q, ldRem_d;
    logic [FLC_W-1:0] flRem_q, flRem_d;
    logic             redirect_q, redirect_d;
    logic [PC_W-1:0]  redirPc_q, redirPc_d;
    logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
    logic [CNT_W-1:0] flushCnt_q, flushCnt_d;
    logic [CNT_W-1:0] cycleCnt_q, cycleCnt_d;
    logic             done_q, done_d;

    logic [REG_W-1:0] rsAddr, rtAddr, dstAddr;
    logic             hz;
    logic             br;
    logic             anyStall;
    logic             bubble;
    logic             flush;

    assign rsAddr  = ctrl_io.RsAddr_ID;
    assign rtAddr  = ctrl_io.RtAddr_ID;
    assign dstAddr = ctrl_io.DstAddr_EX;

    assign hz = ctrl_io.RegWrite_EX && ctrl_io.MemToReg_EX && (dstAddr != '0) &&
                ((ctrl_io.UseRs_ID && (rsAddr == dstAddr)) ||
                 (ctrl_io.UseRt_ID && (rtAddr == dstAddr)));

    // A busy EX stage cannot retire its branch, so the branch only counts once EX is free.
    assign br = ctrl_io.BranchTaken_EX && !ctrl_io.Stall_EX;

    // ldRem_q holds load-stall cycles still owed; it survives BUSY so the stall resumes afterwards.
    always_comb begin
        state_d    = state_q;
        ldRem_d    = ldRem_q;
        flRem_d    = flRem_q;
        redirect_d = 1'b0;
        redirPc_d  = redirPc_q;
        anyStall   = 1'b0;
        bubble     = 1'b0;
        flush      = 1'b0;

        if (br) begin
            flush      = 1'b1;
            ldRem_d    = '0;
            redirect_d = 1'b1;
            redirPc_d  = ctrl_io.RedirectPc_EX;
            if (FLUSH_DEPTH > 1) begin
                state_d = FLUSH;
                flRem_d = FLC_W'(FLUSH_DEPTH - 1);
            end else begin
                state_d = RUN;
                flRem_d = '0;
            end
        end else if (ctrl_io.Stall_EX) begin
            anyStall = 1'b1;
            state_d  = BUSY;
            flRem_d  = '0;
        end else if (ldRem_q != '0) begin
            anyStall = 1'b1;
            bubble   = 1'b1;
            ldRem_d  = ldRem_q - 1'b1;
            state_d  = (ldRem_q == LDC_W'(1)) ? RUN : LDUSE;
        end else if (state_q == FLUSH) begin
            flush   = 1'b1;
            flRem_d = flRem_q - 1'b1;
            state_d = (flRem_q == FLC_W'(1)) ? RUN : FLUSH;
        end else begin
            state_d = RUN;
            if (hz) begin
                anyStall = 1'b1;
                bubble   = 1'b1;
                if (LOAD_LAT > 1) begin
                    state_d = LDUSE;
                    ldRem_d = LDC_W'(LOAD_LAT - 1);
                end
            end
        end
    end

    always_comb begin
        stallCnt_d = stallCnt_q;
        flushCnt_d = flushCnt_q;
        cycleCnt_d = cycleCnt_q;
        if (anyStall && (stallCnt_q != CNT_MAX)) begin
            stallCnt_d = stallCnt_q + 1'b1;
        end
        if (br && (flushCnt_q != CNT_MAX)) begin
            flushCnt_d = flushCnt_q + 1'b1;
        end
        if (cycleCnt_q != CNT_MAX) begin
            cycleCnt_d = cycleCnt_q + 1'b1;
        end
        done_d = done_q || (32'(cycleCnt_d) == MAX_CYCLES);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            ldRem_q    <= '0;
            flRem_q    <= '0;
            redirect_q <= 1'b0;
            redirPc_q  <= '0;
            stallCnt_q <= '0;
            flushCnt_q <= '0;
            cycleCnt_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ldRem_q    <= ldRem_d;
            flRem_q    <= flRem_d;
            redirect_q <= redirect_d;
            redirPc_q  <= redirPc_d;
            stallCnt_q <= stallCnt_d;
            flushCnt_q <= flushCnt_d;
            cycleCnt_q <= cycleCnt_d;
            done_q     <= done_d;
        end
    end

    // Combinational controls are forced low during reset so the pipe sees a clean idle at once.
    assign ctrl_io.AnyStall      = anyStall && !reset;
    assign ctrl_io.Bubble_EX     = bubble && !reset;
    assign ctrl_io.Flush_IF      = flush && !reset;
    assign ctrl_io.Flush_ID      = flush && !reset;
    assign ctrl_io.Redirect_IF   = redirect_q;
    assign ctrl_io.RedirectPc_IF = redirPc_q;
    assign ctrl_io.StallCnt      = stallCnt_q;
    assign ctrl_io.FlushCnt      = flushCnt_q;
    assign ctrl_io.CycleCnt      = cycleCnt_q;
    assign ctrl_io.Done          = done_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: an owed-cycles behavioural model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_hazard_ctrl;

    localparam int LL   = 2;
    localparam int FD   = 2;
    localparam int CW   = 4;
    localparam int MAXC = 10;
    localparam int SAT  = (1 << CW) - 1;

    logic clk;
    logic reset;

    int compared;
    int mismatched;

    hazard_ctrl_if #(.REG_W(5), .PC_W(32), .CNT_W(CW)) hif ();

    hazard_ctrl #(
        .REG_W(5), .PC_W(32), .LOAD_LAT(LL), .FLUSH_DEPTH(FD),
        .CNT_W(CW), .MAX_CYCLES(MAXC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ctrl_io(hif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one input pattern for n cycles; always called and returns at posedge+1.
    task automatic applyStimulus(input logic bt, input logic sx, input logic re, input logic mr,
                                 input logic uRs, input logic [4:0] rs, input logic uRt,
                                 input logic [4:0] rt, input logic [4:0] dst,
                                 input logic [31:0] pc, input int n);
        hif.BranchTaken_EX = bt;
        hif.Stall_EX       = sx;
        hif.RegWrite_EX    = re;
        hif.MemToReg_EX    = mr;
        hif.UseRs_ID       = uRs;
        hif.RsAddr_ID      = rs;
        hif.UseRt_ID       = uRt;
        hif.RtAddr_ID      = rt;
        hif.DstAddr_EX     = dst;
        hif.RedirectPc_EX  = pc;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        applyStimulus(0, 0, 0, 0, 0, 5'd0, 0, 5'd0, 5'd0, 32'h0, n);
    endtask

    task automatic doReset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Model: stall cycles owed by a load, flush cycles left in the window, and counters.
    int          owed, flushLeft, mStallCnt, mFlushCnt, mCycle;
    logic        mRedir, mDone;
    logic [31:0] mPc;
    int          nOwed, nFlushLeft, nStallCnt, nFlushCnt, nCycle;
    logic        nRedir, nDone;
    logic [31:0] nPc;
    logic        eStall, eBubble, eFlush, hzNow, brNow;

    initial begin
        forever begin
            @(negedge clk);
            eStall  = 0;
            eBubble = 0;
            eFlush  = 0;
            if (reset) begin
                owed = 0; flushLeft = 0; mStallCnt = 0; mFlushCnt = 0; mCycle = 0;
                mRedir = 0; mDone = 0; mPc = 0;
            end
            nOwed = owed; nFlushLeft = flushLeft; nStallCnt = mStallCnt;
            nFlushCnt = mFlushCnt; nRedir = 0; nPc = mPc;
            if (!reset) begin
                hzNow = hif.RegWrite_EX && hif.MemToReg_EX && (hif.DstAddr_EX != 0) &&
                        ((hif.UseRs_ID && hif.RsAddr_ID == hif.DstAddr_EX) ||
                         (hif.UseRt_ID && hif.RtAddr_ID == hif.DstAddr_EX));
                brNow = hif.BranchTaken_EX && !hif.Stall_EX;
                if (brNow) begin
                    eFlush = 1; nOwed = 0; nFlushLeft = FD - 1;
                    nRedir = 1; nPc = hif.RedirectPc_EX;
                    nFlushCnt = (mFlushCnt < SAT) ? mFlushCnt + 1 : SAT;
                end else if (hif.Stall_EX) begin
                    eStall = 1; nFlushLeft = 0;
                end else if (owed > 0) begin
                    eStall = 1; eBubble = 1; nOwed = owed - 1;
                end else if (flushLeft > 0) begin
                    eFlush = 1; nFlushLeft = flushLeft - 1;
                end else if (hzNow) begin
                    eStall = 1; eBubble = 1; nOwed = LL - 1;
                end
                if (eStall) nStallCnt = (mStallCnt < SAT) ? mStallCnt + 1 : SAT;
            end
            nCycle = (mCycle < SAT) ? mCycle + 1 : SAT;
            nDone  = mDone || (nCycle == MAXC);

            checkOutput("AnyStall", 32'(hif.AnyStall), 32'(eStall));
            checkOutput("Bubble_EX", 32'(hif.Bubble_EX), 32'(eBubble));
            checkOutput("Flush_IF", 32'(hif.Flush_IF), 32'(eFlush));
            checkOutput("Flush_ID", 32'(hif.Flush_ID), 32'(eFlush));
            checkOutput("Redirect_IF", 32'(hif.Redirect_IF), 32'(mRedir));
            checkOutput("RedirectPc_IF", hif.RedirectPc_IF, mPc);
            checkOutput("StallCnt", 32'(hif.StallCnt), 32'(mStallCnt));
            checkOutput("FlushCnt", 32'(hif.FlushCnt), 32'(mFlushCnt));
            checkOutput("CycleCnt", 32'(hif.CycleCnt), 32'(mCycle));
            checkOutput("Done", 32'(hif.Done), 32'(mDone));

            @(posedge clk);
            if (!reset) begin
                owed = nOwed; flushLeft = nFlushLeft; mStallCnt = nStallCnt;
                mFlushCnt = nFlushCnt; mCycle = nCycle; mRedir = nRedir; mPc = nPc;
                mDone = nDone;
            end
        end
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        hif.BranchTaken_EX = 0; hif.Stall_EX = 0; hif.RegWrite_EX = 0; hif.MemToReg_EX = 0;
        hif.UseRs_ID = 0; hif.RsAddr_ID = 0; hif.UseRt_ID = 0; hif.RtAddr_ID = 0;
        hif.DstAddr_EX = 0; hif.RedirectPc_EX = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Load to r5, ID reads rt=r5: two stall cycles.
        applyStimulus(0, 0, 1, 1, 0, 5'd0, 1, 5'd5, 5'd5, 32'h0, 1);
        idle(3);
        checkOutput("lit_ld_rt_stallcnt", 32'(hif.StallCnt), 32'd2);

        // No hazard: r0 destination, unused rt, non-load write; then an rs match does stall.
        doReset();
        applyStimulus(0, 0, 1, 1, 0, 5'd0, 1, 5'd0, 5'd0, 32'h0, 2);
        applyStimulus(0, 0, 1, 1, 1, 5'd7, 0, 5'd5, 5'd5, 32'h0, 2);
        applyStimulus(0, 0, 1, 0, 1, 5'd5, 1, 5'd5, 5'd5, 32'h0, 2);
        checkOutput("lit_nohz_stallcnt", 32'(hif.StallCnt), 32'd0);
        applyStimulus(0, 0, 1, 1, 1, 5'd9, 0, 5'd0, 5'd9, 32'h0, 1);
        idle(2);
        checkOutput("lit_ld_rs_stallcnt", 32'(hif.StallCnt), 32'd2);

        // Taken branch to 0x40.
        doReset();
        applyStimulus(1, 0, 0, 0, 0, 5'd0, 0, 5'd0, 5'd0, 32'h40, 1);
        checkOutput("lit_br_redirect", 32'(hif.Redirect_IF), 32'd1);
        checkOutput("lit_br_pc", hif.RedirectPc_IF, 32'h40);
        checkOutput("lit_br_flush_t1", 32'(hif.Flush_IF), 32'd1);
        idle(1);
        checkOutput("lit_br_pulse_end", 32'(hif.Redirect_IF), 32'd0);
        checkOutput("lit_br_flush_end", 32'(hif.Flush_IF), 32'd0);
        idle(2);
        checkOutput("lit_br_flushcnt", 32'(hif.FlushCnt), 32'd1);

        // Stall_EX with branch and hazard present, then hazard resolved.
        doReset();
        applyStimulus(1, 1, 1, 1, 0, 5'd0, 1, 5'd6, 5'd6, 32'h80, 3);
        applyStimulus(0, 0, 1, 1, 0, 5'd0, 1, 5'd6, 5'd6, 32'h0, 1);
        idle(3);
        checkOutput("lit_busy_stallcnt", 32'(hif.StallCnt), 32'd5);
        checkOutput("lit_busy_flushcnt", 32'(hif.FlushCnt), 32'd0);

        // Branch arriving in the second load-use cycle.
        doReset();
        applyStimulus(0, 0, 1, 1, 0, 5'd0, 1, 5'd5, 5'd5, 32'h0, 1);
        applyStimulus(1, 0, 0, 0, 0, 5'd0, 0, 5'd0, 5'd0, 32'h100, 1);
        idle(3);
        checkOutput("lit_ldbr_stallcnt", 32'(hif.StallCnt), 32'd1);
        checkOutput("lit_ldbr_flushcnt", 32'(hif.FlushCnt), 32'd1);

        // Stall_EX interrupting a load-use stall; owed cycle resumes afterwards.
        doReset();
        applyStimulus(0, 0, 1, 1, 0, 5'd0, 1, 5'd5, 5'd5, 32'h0, 1);
        applyStimulus(0, 1, 0, 0, 0, 5'd0, 0, 5'd0, 5'd0, 32'h0, 2);
        idle(3);
        checkOutput("lit_ldbusy_stallcnt", 32'(hif.StallCnt), 32'd4);

        // Branch inside the flush window reloads the target.
        doReset();
        applyStimulus(1, 0, 0, 0, 0, 5'd0, 0, 5'd0, 5'd0, 32'h40, 1);
        applyStimulus(1, 0, 0, 0, 0, 5'd0, 0, 5'd0, 5'd0, 32'h80, 1);
        idle(3);
        checkOutput("lit_rebr_pc", hif.RedirectPc_IF, 32'h80);
        checkOutput("lit_rebr_flushcnt", 32'(hif.FlushCnt), 32'd2);

        // Cycle limit and counter saturation.
        doReset();
        idle(9);
        checkOutput("lit_cyc9", 32'(hif.CycleCnt), 32'd9);
        checkOutput("lit_done9", 32'(hif.Done), 32'd0);
        idle(1);
        checkOutput("lit_done10", 32'(hif.Done), 32'd1);
        idle(10);
        checkOutput("lit_cycsat", 32'(hif.CycleCnt), 32'd15);
        checkOutput("lit_donehold", 32'(hif.Done), 32'd1);

        // Reset asserted mid-flush with stall and hazard inputs active.
        doReset();
        applyStimulus(1, 0, 0, 0, 0, 5'd0, 0, 5'd0, 5'd0, 32'h40, 1);
        hif.Stall_EX = 1;
        reset = 1'b1;
        #2;
        checkOutput("lit_rst_flush", 32'(hif.Flush_IF), 32'd0);
        checkOutput("lit_rst_stall", 32'(hif.AnyStall), 32'd0);
        checkOutput("lit_rst_redirect", 32'(hif.Redirect_IF), 32'd0);
        checkOutput("lit_rst_pc", hif.RedirectPc_IF, 32'h0);
        checkOutput("lit_rst_cycle", 32'(hif.CycleCnt), 32'd0);
        checkOutput("lit_rst_flushcnt", 32'(hif.FlushCnt), 32'd0);
        idle(1);
        reset = 1'b0;
        idle(2);

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
